// File: rtl/tl45_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tl45_fetch
//  Purpose  : TL45 instruction fetch stage. Keeps the program counter, reads
//             one word at a time over a pipelined Wishbone master and hands
//             {pc, inst} to decode. Supports decode stall and PC redirect.
//  Revision : 1.0 - initial release
// ============================================================================
module tl45_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_pipe_stall,
  input  logic        i_new_pc,
  input  logic [31:0] i_pc,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic [29:0] o_wb_addr,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_buf_pc,
  output logic [31:0] o_buf_inst,
  output logic        o_fetch_err
);

  // Word-aligned reset vector; low bits are never allowed to leak into pc.
  localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_ABORT = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t      r_state, w_state_nx;
  logic [31:0] r_pc, w_pc_nx;
  logic [31:0] r_stash, w_stash_nx;
  logic [31:0] r_buf_pc, w_buf_pc_nx;
  logic [31:0] r_buf_inst, w_buf_inst_nx;
  logic        r_err, w_err_nx;
  logic        w_redirect;
  logic [31:0] w_pc_inc;
  logic        w_unused;

  // Target alignment bits are dropped, so they are intentionally unused.
  assign w_unused   = &{1'b0, i_pc[1:0]};
  assign w_pc_inc   = r_pc + 32'd4;
  // A redirect is honoured everywhere except before the first fetch and after a bus error.
  assign w_redirect = i_new_pc && (r_state != S_IDLE) && (r_state != S_HALT);

  // Next-state and datapath: redirect has top priority, then err, then ack.
  always_comb begin
    w_state_nx    = r_state;
    w_pc_nx       = r_pc;
    w_stash_nx    = r_stash;
    w_err_nx      = r_err;
    // No delivery: bubble if decode advances, otherwise hold what it sees.
    w_buf_pc_nx   = i_pipe_stall ? r_buf_pc   : 32'h0;
    w_buf_inst_nx = i_pipe_stall ? r_buf_inst : 32'h0;

    if (w_redirect) begin
      w_state_nx    = S_ABORT;
      w_pc_nx       = {i_pc[31:2], 2'b00};
      w_stash_nx    = 32'h0;
      w_buf_pc_nx   = 32'h0;
      w_buf_inst_nx = 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nx = S_REQ;
        end
        S_REQ: begin
          if (!i_wb_stall) begin
            w_state_nx = S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_wb_err) begin
            w_err_nx      = 1'b1;
            w_buf_pc_nx   = 32'h0;
            w_buf_inst_nx = 32'h0;
            w_state_nx    = S_HALT;
          end else if (i_wb_ack) begin
            if (!i_pipe_stall) begin
              w_buf_inst_nx = i_wb_data;
              w_buf_pc_nx   = r_pc;
              w_pc_nx       = w_pc_inc;
              w_state_nx    = S_REQ;
            end else begin
              w_stash_nx    = i_wb_data;
              w_state_nx    = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!i_pipe_stall) begin
            w_buf_inst_nx = r_stash;
            w_buf_pc_nx   = r_pc;
            w_pc_nx       = w_pc_inc;
            w_state_nx    = S_REQ;
          end
        end
        S_ABORT: begin
          w_state_nx = S_REQ;
        end
        S_HALT: begin
          w_buf_pc_nx   = 32'h0;
          w_buf_inst_nx = 32'h0;
        end
        default: begin
          w_state_nx = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_pc       <= c_reset_pc;
      r_stash    <= 32'h0;
      r_buf_pc   <= 32'h0;
      r_buf_inst <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_stash    <= w_stash_nx;
      r_buf_pc   <= w_buf_pc_nx;
      r_buf_inst <= w_buf_inst_nx;
      r_err      <= w_err_nx;
    end
  end

  // Bus signals decode straight from state; dropping cyc ends any open cycle.
  assign o_wb_cyc    = (r_state == S_REQ) || (r_state == S_WAIT);
  assign o_wb_stb    = (r_state == S_REQ);
  assign o_wb_addr   = r_pc[31:2];
  assign o_buf_pc    = r_buf_pc;
  assign o_buf_inst  = r_buf_inst;
  assign o_fetch_err = r_err;

endmodule
`default_nettype wire
